// File: rtl/uart_transceiver.sv
// ============================================================================
// Module      : uart_transceiver
// Description : Full-duplex UART. The transmitter serialises bytes onto TXD.
//               The receiver oversamples RXD and takes a majority vote per bit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_transceiver #(
  parameter int BIT_WIDTH_BITS    = 9,
  parameter int SAMPLE_WIDTH_BITS = 7,
  parameter int SAMPLE_BITS       = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIT_WIDTH_BITS-1:0]    bit_width,
  input  logic [SAMPLE_WIDTH_BITS-1:0] sample_width,
  input  logic                         en_parity,
  input  logic                         odd_parity,
  input  logic [1:0]                   data_bits,
  input  logic                         tx_en,
  input  logic [7:0]                   tx_data,
  output logic                         TXD,
  output logic                         can_snd,
  input  logic                         RXD,
  output logic                         rx_en,
  output logic [7:0]                   rx_data,
  output logic                         parity_valid
);

  localparam int SC_W = $clog2(SAMPLE_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Index of the last data bit and the mask of used data bits
  logic [2:0] w_nbits_m1;
  logic [7:0] w_data_mask;
  assign w_nbits_m1  = (data_bits == 2'd0) ? 3'd7 : ({1'b0, data_bits} + 3'd3);
  assign w_data_mask = 8'hFF >> (3'd7 - w_nbits_m1);

  // ---------------------------------------------------------------- transmit
  state_t                    tx_state_q, tx_state_d;
  logic [BIT_WIDTH_BITS-1:0] tx_cnt_q, tx_cnt_d, tx_bw_q, tx_bw_d;
  logic [7:0]                tx_shift_q, tx_shift_d;
  logic [2:0]                tx_bit_q, tx_bit_d, tx_last_q, tx_last_d;
  logic                      tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
  logic                      txd_q, txd_d, can_snd_q, can_snd_d;
  logic                      w_tx_bit_end, w_tx_accept;

  assign w_tx_bit_end = (tx_cnt_q == tx_bw_q);
  // A request on the edge that ends the stop bit starts the next frame with no idle gap
  assign w_tx_accept  = tx_en && (can_snd_q || (tx_state_q == S_STOP && w_tx_bit_end));

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bw_d     = tx_bw_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    tx_last_d   = tx_last_q;
    tx_par_en_d = tx_par_en_q;
    tx_par_d    = tx_par_q;
    txd_d       = txd_q;
    can_snd_d   = can_snd_q;
    if (tx_state_q != S_IDLE) begin
      tx_cnt_d = w_tx_bit_end ? '0 : tx_cnt_q + BIT_WIDTH_BITS'(1);
    end
    if (w_tx_bit_end) begin
      case (tx_state_q)
        S_START: begin
          tx_state_d = S_DATA;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end
        S_DATA: begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == tx_last_q) begin
            tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
            txd_d      = tx_par_en_q ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_shift_q[1];
          end
        end
        S_PARITY: begin
          tx_state_d = S_STOP;
          txd_d      = 1'b1;
        end
        S_STOP: begin
          tx_state_d = S_IDLE;
          txd_d      = 1'b1;
          can_snd_d  = 1'b1;
        end
        default: ;
      endcase
    end
    if (w_tx_accept) begin
      tx_state_d  = S_START;
      tx_cnt_d    = '0;
      tx_bw_d     = bit_width;
      tx_shift_d  = tx_data;
      tx_last_d   = w_nbits_m1;
      tx_par_en_d = en_parity;
      tx_par_d    = ^(tx_data & w_data_mask) ^ odd_parity;
      txd_d       = 1'b0;
      can_snd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bw_q     <= '0;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      tx_last_q   <= '0;
      tx_par_en_q <= 1'b0;
      tx_par_q    <= 1'b0;
      txd_q       <= 1'b1;
      can_snd_q   <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bw_q     <= tx_bw_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_last_q   <= tx_last_d;
      tx_par_en_q <= tx_par_en_d;
      tx_par_q    <= tx_par_d;
      txd_q       <= txd_d;
      can_snd_q   <= can_snd_d;
    end
  end

  assign TXD     = txd_q;
  assign can_snd = can_snd_q;

  // ----------------------------------------------------------------- receive
  state_t                       rx_state_q, rx_state_d;
  logic                         rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [SAMPLE_WIDTH_BITS-1:0] rx_cnt_q, rx_cnt_d, rx_sw_q, rx_sw_d;
  logic [SC_W-1:0]              rx_smp_q, rx_smp_d, rx_ones_q, rx_ones_d;
  logic [2:0]                   rx_bit_q, rx_bit_d, rx_last_q, rx_last_d;
  logic                         rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
  logic [7:0]                   rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                         rx_pbit_q, rx_pbit_d;
  logic                         rx_en_q, rx_en_d, parity_valid_q, parity_valid_d;
  logic [SAMPLE_WIDTH_BITS:0]   w_sw_p1;
  logic [SC_W-1:0]              w_ones_total;
  logic                         w_sample, w_bit_done, w_bit_val;

  assign w_sw_p1      = {1'b0, sample_width} + {{SAMPLE_WIDTH_BITS{1'b0}}, 1'b1};
  assign w_sample     = (rx_state_q != S_IDLE) && (rx_cnt_q == '0);
  assign w_ones_total = rx_ones_q + SC_W'(rxd_s2_q);
  assign w_bit_done   = w_sample && (rx_smp_q == SC_W'(SAMPLE_BITS - 1));
  assign w_bit_val    = (w_ones_total > SC_W'(SAMPLE_BITS / 2));

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_sw_d        = rx_sw_q;
    rx_smp_d       = rx_smp_q;
    rx_ones_d      = rx_ones_q;
    rx_bit_d       = rx_bit_q;
    rx_last_d      = rx_last_q;
    rx_par_en_d    = rx_par_en_q;
    rx_odd_d       = rx_odd_q;
    rx_shift_d     = rx_shift_q;
    rx_pbit_d      = rx_pbit_q;
    rx_en_d        = 1'b0;
    rx_data_d      = rx_data_q;
    parity_valid_d = parity_valid_q;
    if (rx_state_q == S_IDLE) begin
      if (rxd_prev_q && !rxd_s2_q) begin
        rx_state_d  = S_START;
        rx_cnt_d    = w_sw_p1[SAMPLE_WIDTH_BITS:1];
        rx_sw_d     = sample_width;
        rx_smp_d    = '0;
        rx_ones_d   = '0;
        rx_last_d   = w_nbits_m1;
        rx_par_en_d = en_parity;
        rx_odd_d    = odd_parity;
        rx_shift_d  = '0;
      end
    end else begin
      if (w_sample) begin
        rx_cnt_d  = rx_sw_q;
        rx_smp_d  = w_bit_done ? '0 : rx_smp_q + SC_W'(1);
        rx_ones_d = w_bit_done ? '0 : w_ones_total;
      end else begin
        rx_cnt_d = rx_cnt_q - SAMPLE_WIDTH_BITS'(1);
      end
      if (w_bit_done) begin
        case (rx_state_q)
          S_START: begin
            rx_state_d = w_bit_val ? S_IDLE : S_DATA;
            rx_bit_d   = 3'd0;
          end
          S_DATA: begin
            rx_shift_d[rx_bit_q] = w_bit_val;
            if (rx_bit_q == rx_last_q) begin
              rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end
          S_PARITY: begin
            rx_pbit_d  = w_bit_val;
            rx_state_d = S_STOP;
          end
          S_STOP: begin
            // A zero stop bit is a framing error, but the byte is still delivered
            rx_state_d     = S_IDLE;
            rx_en_d        = 1'b1;
            rx_data_d      = rx_shift_q;
            parity_valid_d = rx_par_en_q ? ~(^rx_shift_q ^ rx_pbit_q ^ rx_odd_q) : 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q       <= 1'b1;
      rxd_s2_q       <= 1'b1;
      rxd_prev_q     <= 1'b1;
      rx_state_q     <= S_IDLE;
      rx_cnt_q       <= '0;
      rx_sw_q        <= '0;
      rx_smp_q       <= '0;
      rx_ones_q      <= '0;
      rx_bit_q       <= '0;
      rx_last_q      <= '0;
      rx_par_en_q    <= 1'b0;
      rx_odd_q       <= 1'b0;
      rx_shift_q     <= '0;
      rx_pbit_q      <= 1'b0;
      rx_en_q        <= 1'b0;
      rx_data_q      <= '0;
      parity_valid_q <= 1'b0;
    end else begin
      rxd_s1_q       <= RXD;
      rxd_s2_q       <= rxd_s1_q;
      rxd_prev_q     <= rxd_s2_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_sw_q        <= rx_sw_d;
      rx_smp_q       <= rx_smp_d;
      rx_ones_q      <= rx_ones_d;
      rx_bit_q       <= rx_bit_d;
      rx_last_q      <= rx_last_d;
      rx_par_en_q    <= rx_par_en_d;
      rx_odd_q       <= rx_odd_d;
      rx_shift_q     <= rx_shift_d;
      rx_pbit_q      <= rx_pbit_d;
      rx_en_q        <= rx_en_d;
      rx_data_q      <= rx_data_d;
      parity_valid_q <= parity_valid_d;
    end
  end

  assign rx_en        = rx_en_q;
  assign rx_data      = rx_data_q;
  assign parity_valid = parity_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_transceiver.sv
// ============================================================================
// Module      : tb_uart_transceiver
// Description : Scoreboard bench for uart_transceiver with TXD looped to RXD.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_transceiver;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] bit_width;
  logic [6:0] sample_width;
  logic       en_parity, odd_parity;
  logic [1:0] data_bits;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       txd, can_snd, rxd;
  logic       rx_en, parity_valid;
  logic [7:0] rx_data;
  logic       use_inj, inj;

  assign rxd = use_inj ? inj : txd;

  always #10 clk = ~clk;

  uart_transceiver dut (
    .clk(clk), .rst(rst), .bit_width(bit_width), .sample_width(sample_width),
    .en_parity(en_parity), .odd_parity(odd_parity), .data_bits(data_bits),
    .tx_en(tx_en), .tx_data(tx_data), .TXD(txd), .can_snd(can_snd),
    .RXD(rxd), .rx_en(rx_en), .rx_data(rx_data), .parity_valid(parity_valid)
  );

  typedef struct {
    logic [7:0] d;
    logic       pv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every rx_en pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (rx_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual rx_data=%0h required no rx_en", rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e.d});
        check("parity_valid", {31'd0, parity_valid}, {31'd0, e.pv});
      end
    end
  end

  function automatic logic [7:0] mask8(input logic [1:0] db);
    case (db)
      2'd0:    return 8'hFF;
      2'd1:    return 8'h1F;
      2'd2:    return 8'h3F;
      default: return 8'h7F;
    endcase
  endfunction

  function automatic int nbits(input logic [1:0] db);
    return (db == 2'd0) ? 8 : 4 + int'(db);
  endfunction

  task automatic set_cfg(input int bw, input int sw, input logic par, input logic odd,
                         input logic [1:0] db);
    bit_width    = 9'(bw);
    sample_width = 7'(sw);
    en_parity    = par;
    odd_parity   = odd;
    data_bits    = db;
  endtask

  task automatic push(input logic [7:0] d, input logic pv);
    exp_t e;
    e.d  = d;
    e.pv = pv;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (can_snd !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL can_snd_timeout actual=0 required=1");
    end
  endtask

  // Returns just after the accepting edge
  task automatic send_one(input logic [7:0] b);
    wait_idle();
    @(negedge clk);
    tx_data = b;
    tx_en   = 1'b1;
    @(posedge clk);
    #1 tx_en = 1'b0;
  endtask

  task automatic capture(input int n, input int p, output logic [11:0] seq);
    seq = '0;
    repeat (p / 2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      seq[i] = txd;
      repeat (p) @(negedge clk);
    end
  endtask

  task automatic inject(input logic [11:0] bits, input int n, input int p);
    use_inj = 1'b1;
    inj     = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      inj = bits[i];
      repeat (p) @(negedge clk);
    end
    inj = 1'b1;
    repeat (2 * p) @(negedge clk);
    use_inj = 1'b0;
  endtask

  // Back-to-back frames: tx_en held high, new byte presented after every accept
  task automatic burst(input logic par, input logic odd, input logic [1:0] db, input int cnt);
    int         f;
    logic [7:0] b;
    f = 2 + nbits(db) + (par ? 1 : 0);
    set_cfg(24, 4, par, odd, db);
    wait_idle();
    @(negedge clk);
    b       = 8'($urandom_range(0, 255));
    tx_data = b;
    tx_en   = 1'b1;
    push(b & mask8(db), 1'b1);
    @(posedge clk);
    for (int k = 1; k < cnt; k++) begin
      #1;
      b       = 8'($urandom_range(0, 255));
      tx_data = b;
      push(b & mask8(db), 1'b1);
      repeat (f * 25) @(posedge clk);
    end
    #1 tx_en = 1'b0;
    wait_idle();
    repeat (30) @(negedge clk);
  endtask

  initial begin
    logic [11:0] seq;
    int          low_cnt;

    rst = 1'b1;
    tx_en = 1'b0;
    tx_data = 8'h00;
    use_inj = 1'b0;
    inj = 1'b1;
    set_cfg(433, 85, 1'b0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    check("reset_TXD", {31'd0, txd}, 32'd1);
    check("reset_can_snd", {31'd0, can_snd}, 32'd1);
    check("reset_rx_en", {31'd0, rx_en}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_parity_valid", {31'd0, parity_valid}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 at 115200 baud
    push(8'hA5, 1'b1);
    send_one(8'hA5);
    fork
      capture(10, 434, seq);
      begin
        int c = 0;
        @(negedge clk);
        while (can_snd === 1'b0 && c < 10000) begin
          c++;
          @(negedge clk);
        end
        low_cnt = c;
      end
    join
    check("txd_seq_A5", {20'd0, seq}, 32'h34A);
    check("can_snd_low_clks", low_cnt, 32'd4340);
    repeat (30) @(negedge clk);

    // 7O1 0xC3: parity bit 0, received 0x43
    set_cfg(24, 4, 1'b1, 1'b1, 2'd3);
    push(8'h43, 1'b1);
    send_one(8'hC3);
    capture(10, 25, seq);
    check("txd_seq_7O1_C3", {20'd0, seq}, 32'h286);
    wait_idle();
    repeat (30) @(negedge clk);

    // 5E1 0x17
    set_cfg(24, 4, 1'b1, 1'b0, 2'd1);
    push(8'h17, 1'b1);
    send_one(8'h17);
    wait_idle();
    repeat (30) @(negedge clk);

    // All 12 formats, back-to-back random bytes
    for (int p = 0; p < 3; p++) begin
      for (int d = 0; d < 4; d++) begin
        burst(p != 0, p == 2, 2'(d), 17);
      end
    end

    // Injected 8E1 frame 0x01 with a wrong parity bit
    set_cfg(24, 4, 1'b1, 1'b0, 2'd0);
    push(8'h01, 1'b0);
    inject(12'h402, 11, 25);
    repeat (30) @(negedge clk);

    // Idle glitch must not produce a frame; the following frame must
    set_cfg(433, 85, 1'b0, 1'b0, 2'd0);
    use_inj = 1'b1;
    inj = 1'b1;
    repeat (5) @(negedge clk);
    inj = 1'b0;
    repeat (50) @(negedge clk);
    inj = 1'b1;
    repeat (600) @(negedge clk);
    use_inj = 1'b0;
    push(8'h3C, 1'b1);
    send_one(8'h3C);
    wait_idle();
    repeat (50) @(negedge clk);

    // tx_en while busy is ignored
    set_cfg(24, 4, 1'b0, 1'b0, 2'd0);
    push(8'h5A, 1'b1);
    send_one(8'h5A);
    for (int i = 0; i < 3; i++) begin
      repeat (40) @(negedge clk);
      tx_data = 8'hFF;
      tx_en = 1'b1;
      @(negedge clk);
      tx_en = 1'b0;
    end
    wait_idle();
    repeat (300) @(negedge clk);

    // Reset in the middle of a frame aborts both paths
    send_one(8'h00);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_TXD", {31'd0, txd}, 32'd1);
    check("midrst_can_snd", {31'd0, can_snd}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("postrst_TXD", {31'd0, txd}, 32'd1);

    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
